// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO flow-control slice: default geometry and
// the address-width derivation used by the controller and its storage.
package fifo_pkg;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_DEPTH  = 4;

  // Pointer width for a power-of-two depth; the occupancy counter is one bit wider.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port, no reset on the array
// or the read register.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = addr_w(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [0:(1<<AW)-1];

  // Write and read share the edge; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, threshold flags and sticky
// overflow/underflow errors around a fifo_mem storage array.
module fifo_flow_ctrl
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [AW:0]       af_th,
  input  logic [AW:0]       ae_th,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [AW:0]       count,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              pausa,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              fifo_error
);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_C   = (AW+1)'(0);
  localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              data_valid_r;
  logic              has_data_r;
  logic              overflow_r;
  logic              underflow_r;
  logic [DATA_W-1:0] rd_data_s;

  logic              pop_ok_s;
  logic              push_ok_s;
  logic              ovf_evt_s;
  logic              unf_evt_s;
  logic [AW:0]       count_nxt_s;

  // Accept/reject decisions; a pop on empty is never accepted, and a push on
  // full is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    ovf_evt_s = 1'b0;
    unf_evt_s = 1'b0;
    if (pop && (count_r != ZERO_C)) begin
      pop_ok_s = 1'b1;
    end else begin
      unf_evt_s = pop;
    end
    if (push && ((count_r != DEPTH_C) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      ovf_evt_s = push;
    end
  end

  // Occupancy update from accepted operations only.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count and read-valid tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      data_valid_r <= 1'b0;
      has_data_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_ok_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE_C;
        has_data_r <= 1'b1;
      end
      count_r      <= count_nxt_s;
      data_valid_r <= pop_ok_s;
    end
  end

  // Sticky errors; a new error in the clearing cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end
      if (unf_evt_s) begin
        underflow_r <= 1'b1;
      end else if (err_clr) begin
        underflow_r <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_en   (pop_ok_s),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // The storage read register has no reset, so it is masked until the first pop.
  assign data_out      = has_data_r ? rd_data_s : '0;
  assign data_valid    = data_valid_r;
  assign count         = count_r;
  assign fifo_empty    = (count_r == ZERO_C);
  assign fifo_full     = (count_r == DEPTH_C);
  assign almost_full   = (count_r >= af_th);
  assign almost_empty  = (count_r <= ae_th);
  assign pausa         = almost_full;
  assign overflow_err  = overflow_r;
  assign underflow_err = underflow_r;
  assign fifo_error    = overflow_r | underflow_r;

endmodule

// File: doc/fifo_flow_ctrl.md
FIFO_FLOW_CTRL -- requirements
Module: fifo_flow_ctrl

Interface
REQ-001 Parameter DATA_W, default 6, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of entries; it is a power of two, >= 2; AW = log2(DEPTH).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 push  input  1  SHALL be the write request; data_in is sampled when it is accepted.
REQ-006 pop  input  1  SHALL be the read request.
REQ-007 data_in  input  DATA_W  SHALL be the write data.
REQ-008 af_th  input  AW+1  SHALL be the almost-full threshold, quasi-static.
REQ-009 ae_th  input  AW+1  SHALL be the almost-empty threshold, quasi-static.
REQ-010 err_clr  input  1  SHALL clear the sticky error flags.
REQ-011 data_out  output  DATA_W  SHALL be the registered read data.
REQ-012 data_valid  output  1  SHALL be high for one cycle when data_out carries newly popped data.
REQ-013 count  output  AW+1  SHALL be the current occupancy, 0..DEPTH.
REQ-014 fifo_empty, fifo_full, almost_empty, almost_full, pausa  outputs  1 each  SHALL be the status flags.
REQ-015 overflow_err, underflow_err, fifo_error  outputs  1 each  SHALL be the sticky error flags; fifo_error = overflow_err OR underflow_err.

Function
REQ-016 A push SHALL be accepted when count < DEPTH, or when count == DEPTH and a pop is accepted in the same cycle.
REQ-017 A pop SHALL be accepted only when count > 0; a pop on empty is rejected even if a push occurs in the same cycle.
REQ-018 An accepted pop SHALL load the oldest entry into data_out at the same clock edge; data_valid = 1 for that cycle only, and data_out holds otherwise.
REQ-019 count SHALL update as follows: +1 on a push only, -1 on a pop only, unchanged on both or neither (accepted operations only).
REQ-020 Read and write pointers SHALL be AW bits wide and wrap from DEPTH-1 to 0.
REQ-021 fifo_empty = (count == 0); fifo_full = (count == DEPTH); almost_full = (count >= af_th); almost_empty = (count <= ae_th); pausa = almost_full. All are decoded from registered count, with no combinational path from push or pop.
REQ-022 A push rejected because the FIFO is full SHALL drop the data and set overflow_err; the stored contents are unchanged.
REQ-023 A pop rejected because the FIFO is empty SHALL set underflow_err; data_out holds and data_valid = 0.
REQ-024 Error flags SHALL stay set until err_clr; if err_clr and a new error occur in the same cycle, the flag ends set.
REQ-025 Data order SHALL be strict FIFO under any mix of push, pop and simultaneous push/pop.

Reset
REQ-026 While reset = 1, pointers, count, data_out, data_valid and all error flags SHALL be 0, independent of clk.
REQ-027 After reset: fifo_empty = 1, almost_empty = 1 if ae_th >= 0, fifo_full = 0, almost_full = (af_th == 0).
REQ-028 Storage array contents SHALL NOT be reset; reset mid-operation discards all queued entries.

Structure
REQ-029 Shared package fifo_pkg SHALL hold the default DATA_W and DEPTH constants and the clog2-based AW derivation.
REQ-030 The storage array SHALL be a sub-module fifo_mem (1 write port, 1 synchronous read port, no reset); fifo_flow_ctrl holds pointers, count, flags and errors.

Verification (DATA_W=6, DEPTH=4)
REQ-031 Push 0x11, 0x16, 0x30, 0x1C, then pop x4 -> count reaches 4 and fifo_full = 1; data_out = 0x11, 0x16, 0x30, 0x1C with data_valid each cycle; fifo_empty = 1 at the end.
REQ-032 At count = 2, push 0x1A plus pop for 2 cycles -> count stays 2; output order preserved; no error.
REQ-033 At count = 4, push 0x1E without pop -> overflow_err = 1, fifo_error = 1, and 0x1E never appears on data_out; pulse err_clr -> flags return to 0.
REQ-034 At count = 0, pop alone and pop plus push 0x1D -> underflow_err = 1 and data_valid = 0; in the second case count = 1 and the next pop returns 0x1D.
REQ-035 With af_th = 3 and ae_th = 1 -> pausa rises the cycle count becomes 3 and falls at 2; almost_empty is high for count <= 1.
REQ-036 At count = 3, assert reset asynchronously between edges -> all outputs reset immediately; after release, push 0x2A then pop returns 0x2A.
